// File: rtl/mac_pkg.sv
// Shared defaults and FSM encoding for the mac_stream dot-product block.
package mac_pkg;
  localparam int DEF_LANES = 16;
  localparam int DEF_DW    = 8;
  localparam int DEF_SW    = 20;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/mac_stream_if.sv
// Operand/result handshake bundle for mac_stream; master = producer/consumer side.
interface mac_stream_if
  import mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int SW    = DEF_SW
);
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] p_in;
  logic [LANES*DW-1:0] w_in;
  logic [SW-1:0]       s_out;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (output in_valid, p_in, w_in, out_ready,
                  input  in_ready, s_out, out_valid, busy);
  modport slave  (input  in_valid, p_in, w_in, out_ready,
                  output in_ready, s_out, out_valid, busy);
endinterface

// File: rtl/mac_lane_sel.sv
// Combinational lane picker: returns lane sel of a packed LANES x DW vector.
module mac_lane_sel
  import mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0][DW-1:0] vec,
  input  logic [LW-1:0]            sel,
  output logic [DW-1:0]            lane
);
  assign lane = vec[sel];
endmodule

// File: rtl/mac_stream.sv
// Serial unsigned dot product, one lane per cycle: IDLE -> CALC (LANES cycles) -> DONE.
// Optional MAC_STREAM_CNT_EN adds a wrapping 8-bit result-handshake counter port.
module mac_stream
  import mac_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int SW    = DEF_SW
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MAC_STREAM_CNT_EN
  output logic [7:0] res_count,
`endif
  mac_stream_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  state_t              state;
  logic [LW-1:0]       lane;
  logic [SW-1:0]       acc;
  logic [SW-1:0]       acc_nxt;
  logic [SW-1:0]       s_q;
  logic [LANES*DW-1:0] p_q;
  logic [LANES*DW-1:0] w_q;
  logic [DW-1:0]       p_l;
  logic [DW-1:0]       w_l;
  logic [2*DW-1:0]     prod;

  mac_lane_sel #(.LANES(LANES), .DW(DW), .LW(LW)) u_sel_p (.vec(p_q), .sel(lane), .lane(p_l));
  mac_lane_sel #(.LANES(LANES), .DW(DW), .LW(LW)) u_sel_w (.vec(w_q), .sel(lane), .lane(w_l));

  assign prod    = p_l * w_l;
  assign acc_nxt = acc + SW'(prod);

  // Operands are latched on accept so later input churn cannot disturb CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lane  <= '0;
      acc   <= '0;
      s_q   <= '0;
      p_q   <= '0;
      w_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          p_q   <= bus.p_in;
          w_q   <= bus.w_in;
          acc   <= '0;
          lane  <= '0;
          state <= CALC;
        end
        CALC: begin
          acc  <= acc_nxt;
          lane <= lane + 1'b1;
          if (lane == LAST) begin
            s_q   <= acc_nxt;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.s_out     = s_q;

`ifdef MAC_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                              res_count <= '0;
    else if (state == DONE && bus.out_ready) res_count <= res_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_mac_stream.sv
// Scoreboard bench for mac_stream: expected sums queued on accept, compared on result handshake.
module tb_mac_stream;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_ov = 1'b0;
  logic [19:0] exp_q[$];
  int          acc_q[$];
`ifdef MAC_STREAM_CNT_EN
  logic [7:0] res_count;
`endif

  mac_stream_if #(.LANES(16), .DW(8), .SW(20)) bus ();

  mac_stream #(.LANES(16), .DW(8), .SW(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MAC_STREAM_CNT_EN
    .res_count (res_count),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] dot(input logic [127:0] p, input logic [127:0] w);
    logic [19:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s += 20'(p[8*k +: 8]) * 20'(w[8*k +: 8]);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // accept log: cycle number as seen at the following negedge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
  end

  // result monitor: latency on out_valid rise, value on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("lat_unexp", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), 16);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("res_unexp", {12'h0, bus.s_out}, 32'hDEAD);
        else chk("s_out", {12'h0, bus.s_out}, {12'h0, exp_q.pop_front()});
      end
    end
    prev_ov <= rst_n && bus.out_valid;
  end

  task automatic send(input logic [127:0] p, input logic [127:0] w, output int t);
    int n;
    n = 0;
    t = -1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin chk("rdy_timeout", 0, 1); return; end
    bus.p_in = p; bus.w_in = w; bus.in_valid = 1'b1;
    exp_q.push_back(dot(p, w));
    @(posedge clk); #1;
    t = cyc;
    bus.in_valid = 1'b0;
    bus.p_in = rnd128(); bus.w_in = rnd128();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, n;
    logic [127:0] pa, wa, pb, wb;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.p_in = '0; bus.w_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_s_out",     bus.s_out, 0);

    // zeros, all-ones, sparse lanes; back-to-back spacing
    send('0, '0, t1);
    send({16{8'hFF}}, {16{8'hFF}}, t2);
    chk("throughput", t2 - t1, 18);
    chk("dot_ff_model", dot({16{8'hFF}}, {16{8'hFF}}), 20'hFE010);
    pa = (128'h02 << 120) | 128'h10;
    wa = (128'h03 << 120) | 128'h01;
    send(pa, wa, t1);
    for (int i = 0; i < 4; i++) send(rnd128(), rnd128(), t1);
    drain();

    // output back-pressure with new data waiting
    bus.out_ready = 1'b0;
    pa = rnd128(); wa = rnd128();
    pb = rnd128(); wb = rnd128();
    send(pa, wa, t1);
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    chk("ov_timeout", bus.out_valid, 1);
    bus.p_in = pb; bus.w_in = wb; bus.in_valid = 1'b1;
    exp_q.push_back(dot(pb, wb));
    repeat (5) begin
      @(negedge clk);
      chk("hold_s_out", bus.s_out, dot(pa, wa));
      chk("hold_in_rdy", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    drain();

    // reset mid-CALC at lane 7
    send(rnd128(), rnd128(), t1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("calc_busy", bus.busy, 1);
    chk("calc_in_rdy", bus.in_ready, 0);
    rst_n = 1'b0;
    exp_q.delete(); acc_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_s_out", bus.s_out, 0);
    chk("mrst_in_rdy", bus.in_ready, 1);
    chk("mrst_busy", bus.busy, 0);
    repeat (20) begin @(negedge clk); chk("mrst_no_ov", bus.out_valid, 0); end
    pa = rnd128(); wa = rnd128();
    send(pa, wa, t1);
    drain();

`ifdef MAC_STREAM_CNT_EN
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("cnt_rst", res_count, 0);
    for (int i = 0; i < 257; i++) send(rnd128(), rnd128(), t1);
    drain();
    @(negedge clk);
    chk("res_count", res_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
